msg_serializer: RTL and testbench

//  Consumes msg_parser output (one-cycle msg_valid pulse, length, LSB-first data) and re-emits

---
 rtl/msg_serializer.sv | 181 ++++++++++++++++++
 tb/tb_msg_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serializer.sv
// Buffers parser messages in a DEPTH-entry FIFO and re-emits each one as a 64-bit AXI-Stream packet.
// Optional statistics counters are enabled by defining MSG_SERIALIZER_STATS_EN.
module msg_serializer #(
   parameter int MAX_MSG_BYTES = 32,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       msg_valid,
   input  logic [15:0]                msg_length,
   input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
   input  logic                       m_tready,
   output logic                       m_tvalid,
   output logic [63:0]                m_tdata,
   output logic [7:0]                 m_tkeep,
   output logic                       m_tlast,
   output logic                       msg_drop,
   output logic                       msg_len_err,
   output logic [$clog2(DEPTH):0]     fifo_level
`ifdef MSG_SERIALIZER_STATS_EN
   ,
   output logic [31:0]                stat_msgs_in,
   output logic [31:0]                stat_msgs_out,
   output logic [31:0]                stat_drops
`endif
);

   localparam int LW     = $clog2(MAX_MSG_BYTES) + 1;
   localparam int DW     = 8 * MAX_MSG_BYTES;
   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = AW + 1;
   localparam int NBEATS = (MAX_MSG_BYTES + 7) / 8;
   localparam int SW     = 64 * NBEATS;
   localparam int BW     = $clog2(NBEATS) + 1;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LW-1:0]   r_mem_len  [DEPTH];
   logic [DW-1:0]   r_mem_data [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [PW-1:0]   r_level;
   logic            r_drop;
   logic            r_len_err;
   logic [SW-1:0]   r_shift;
   logic [BW-1:0]   r_beats;
   logic [2:0]      r_len_mod;

   logic            w_len_ok;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_load;
   logic            w_last;
   logic [7:0]      w_last_keep;
   logic [LW-1:0]   w_head_len;
   logic [BW-1:0]   w_head_beats;

   assign w_len_ok     = (msg_length != 16'd0) && (msg_length <= 16'(MAX_MSG_BYTES));
   assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push       = msg_valid && w_len_ok && !w_full;
   assign w_last       = (r_beats == BW'(1));
   assign w_pop        = m_tvalid && m_tready && w_last;
   assign w_head_len   = r_mem_len[r_rptr[AW-1:0]];
   assign w_head_beats = BW'(({3'b000, w_head_len} + (LW + 3)'(7)) >> 3);
   assign w_last_keep  = (r_len_mod == 3'd0) ? 8'hFF : (8'h01 << r_len_mod) - 8'h01;

   // NOTE: storage arrays carry no reset; validity comes solely from the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_len[r_wptr[AW-1:0]]  <= msg_length[LW-1:0];
         r_mem_data[r_wptr[AW-1:0]] <= msg_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_drop    <= 1'b0;
         r_len_err <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + PW'(1);
            2'b01:   r_level <= r_level - PW'(1);
            default: r_level <= r_level;
         endcase
         r_drop    <= msg_valid && w_len_ok && w_full;
         r_len_err <= msg_valid && !w_len_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      m_tvalid    = 1'b0;
      m_tkeep     = 8'h00;
      m_tlast     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_level != '0) begin
               w_load      = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            m_tvalid = 1'b1;
            m_tlast  = w_last;
            m_tkeep  = w_last ? w_last_keep : 8'hFF;
            if (m_tready && w_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bytes outside tkeep are forced to zero, hiding whatever the parser left past the length.
   always_comb begin
      m_tdata = '0;
      for (int i = 0; i < 8; i++) begin
         m_tdata[8*i +: 8] = m_tkeep[i] ? r_shift[8*i +: 8] : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shift   <= '0;
         r_beats   <= '0;
         r_len_mod <= '0;
      end else if (w_load) begin
         r_shift   <= SW'(r_mem_data[r_rptr[AW-1:0]]);
         r_beats   <= w_head_beats;
         r_len_mod <= 3'(w_head_len);
      end else if (m_tvalid && m_tready) begin
         r_shift <= r_shift >> 64;
         r_beats <= r_beats - BW'(1);
      end
   end

   assign msg_drop    = r_drop;
   assign msg_len_err = r_len_err;
   assign fifo_level  = r_level;

`ifdef MSG_SERIALIZER_STATS_EN
   logic [31:0] r_stat_in;
   logic [31:0] r_stat_out;
   logic [31:0] r_stat_drops;
   logic        w_drop_evt;

   assign w_drop_evt = msg_valid && (!w_len_ok || w_full);

   // Counters saturate rather than wrap so a long-running link never reports a small count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stat_in    <= '0;
         r_stat_out   <= '0;
         r_stat_drops <= '0;
      end else begin
         if (w_push && r_stat_in != 32'hFFFF_FFFF)        r_stat_in    <= r_stat_in + 32'd1;
         if (w_pop && r_stat_out != 32'hFFFF_FFFF)        r_stat_out   <= r_stat_out + 32'd1;
         if (w_drop_evt && r_stat_drops != 32'hFFFF_FFFF) r_stat_drops <= r_stat_drops + 32'd1;
      end
   end

   assign stat_msgs_in  = r_stat_in;
   assign stat_msgs_out = r_stat_out;
   assign stat_drops    = r_stat_drops;
`endif

endmodule

// File: tb/tb_msg_serializer.sv
// Scoreboard bench for msg_serializer: a byte-level packet model predicts beats, drops and level,
// and a negedge monitor compares the DUT against it every cycle.
module tb_msg_serializer;

   localparam int MAXB  = 32;
   localparam int DEPTH = 4;
   localparam int LVW   = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              msg_valid;
   logic [15:0]       msg_length;
   logic [8*MAXB-1:0] msg_data;
   logic              m_tready;
   logic              m_tvalid;
   logic [63:0]       m_tdata;
   logic [7:0]        m_tkeep;
   logic              m_tlast;
   logic              msg_drop;
   logic              msg_len_err;
   logic [LVW-1:0]    fifo_level;
`ifdef MSG_SERIALIZER_STATS_EN
   logic [31:0]       stat_msgs_in;
   logic [31:0]       stat_msgs_out;
   logic [31:0]       stat_drops;
`endif

   always #5 clk = ~clk;

   msg_serializer #(.MAX_MSG_BYTES(MAXB), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .msg_valid   (msg_valid),
      .msg_length  (msg_length),
      .msg_data    (msg_data),
      .m_tready    (m_tready),
      .m_tvalid    (m_tvalid),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tlast     (m_tlast),
      .msg_drop    (msg_drop),
      .msg_len_err (msg_len_err),
      .fifo_level  (fifo_level)
`ifdef MSG_SERIALIZER_STATS_EN
      ,
      .stat_msgs_in  (stat_msgs_in),
      .stat_msgs_out (stat_msgs_out),
      .stat_drops    (stat_drops)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   beat_t exp_q[$];
   int    m_stored     = 0;
   int    m_done       = 0;
   int    st_in        = 0;
   int    st_out       = 0;
   int    st_drop      = 0;
   logic  exp_drop     = 1'b0;
   logic  exp_err      = 1'b0;
   int    exp_level    = 0;
   logic  prev_rst_low = 1'b0;
   logic  prev_stall   = 1'b0;

   // Split a message into 8-byte chunks, lowest byte first.
   task automatic model_push(input int len, input logic [8*MAXB-1:0] d);
      beat_t bt;
      for (int b = 0; b < len; b += 8) begin
         bt = '0;
         for (int k = 0; k < 8 && (b + k) < len; k++) begin
            bt.data[8*k +: 8] = d[8*(b+k) +: 8];
            bt.keep[k]        = 1'b1;
         end
         bt.last = (b + 8 >= len);
         exp_q.push_back(bt);
      end
   endtask

   always @(negedge clk) begin : monitor
      int   occ;
      logic len_ok;
      logic was_last;
      check("msg_drop", msg_drop, exp_drop);
      check("msg_len_err", msg_len_err, exp_err);
      check("fifo_level", fifo_level, exp_level);
      if (prev_rst_low) begin
         check("rst_tvalid", m_tvalid, 0);
         check("rst_tdata", m_tdata, 0);
         check("rst_tkeep", m_tkeep, 0);
         check("rst_tlast", m_tlast, 0);
      end
      if (prev_stall) check("tvalid_hold", m_tvalid, 1);
      if (m_tvalid) begin
         if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
         else begin
            check("tdata", m_tdata, exp_q[0].data);
            check("tkeep", m_tkeep, exp_q[0].keep);
            check("tlast", m_tlast, exp_q[0].last);
         end
      end
      prev_stall   = rst && m_tvalid && !m_tready;
      prev_rst_low = !rst;
      if (!rst) begin
         exp_q.delete();
         m_stored  = 0;
         m_done    = 0;
         st_in     = 0;
         st_out    = 0;
         st_drop   = 0;
         exp_drop  = 1'b0;
         exp_err   = 1'b0;
         exp_level = 0;
      end else begin
         occ = m_stored - m_done;
         if (m_tvalid && m_tready && exp_q.size() != 0) begin
            was_last = exp_q[0].last;
            void'(exp_q.pop_front());
            if (was_last) begin
               m_done++;
               st_out++;
            end
         end
         len_ok   = (msg_length >= 16'd1) && (msg_length <= 16'(MAXB));
         exp_err  = msg_valid && !len_ok;
         exp_drop = msg_valid && len_ok && (occ == DEPTH);
         if (msg_valid && len_ok && occ < DEPTH) begin
            model_push(int'(msg_length), msg_data);
            m_stored++;
            st_in++;
         end
         if (exp_err || exp_drop) st_drop++;
         exp_level = m_stored - m_done;
      end
   end

   function automatic logic [8*MAXB-1:0] rand_data();
      logic [8*MAXB-1:0] d;
      for (int i = 0; i < MAXB / 4; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] len, input logic [8*MAXB-1:0] d);
      msg_valid  = 1'b1;
      msg_length = len;
      msg_data   = d;
      tick(1);
      msg_valid  = 1'b0;
   endtask

   task automatic drain();
      logic done;
      done      = 1'b0;
      msg_valid = 1'b0;
      m_tready  = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         if (exp_q.size() == 0 && fifo_level == 0 && !m_tvalid) done = 1'b1;
         else tick(1);
      end
      check("drain_done", done, 1);
   endtask

   initial begin
      logic [8*MAXB-1:0] d;
      rst        = 1'b0;
      msg_valid  = 1'b0;
      msg_length = '0;
      msg_data   = '0;
      m_tready   = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);

      // Stalled sink, five back-to-back messages: fifth overflows
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) push(16'd8, rand_data());
      check("t3_level_full", fifo_level, DEPTH);
      tick(2);
      drain();

      // Illegal lengths never reach the FIFO
      push(16'd0, rand_data());
      push(16'd33, rand_data());
      tick(4);
      check("t4_tvalid", m_tvalid, 0);
      check("t4_level", fifo_level, 0);
`ifdef MSG_SERIALIZER_STATS_EN
      check("t7_stat_in", stat_msgs_in, 4);
      check("t7_stat_out", stat_msgs_out, 4);
      check("t7_stat_drops", stat_drops, 3);
`endif

      // Single short beat, latency from an empty idle FIFO
      d = rand_data();
      d[39:0] = 40'h05_04_03_02_01;
      push(16'd5, d);
      check("t1_not_yet", m_tvalid, 0);
      tick(1);
      check("t1_tvalid", m_tvalid, 1);
      check("t1_tdata", m_tdata, 64'h0504030201);
      check("t1_tkeep", m_tkeep, 8'h1F);
      check("t1_tlast", m_tlast, 1);
      drain();

      // Full-size message
      for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'(i);
      push(16'd32, d);
      drain();

      // Toggling ready: outputs must hold while stalled
      m_tready = 1'b0;
      push(16'd16, rand_data());
      for (int i = 0; i < 12; i++) begin
         m_tready = ~m_tready;
         tick(1);
      end
      drain();

      // Reset in the middle of a four-beat packet
      m_tready = 1'b0;
      push(16'd32, rand_data());
      tick(1);
      check("t6_sending", m_tvalid, 1);
      m_tready = 1'b1;
      tick(1);
      m_tready = 1'b0;
      rst = 1'b0;
      tick(1);
      check("t6_tvalid", m_tvalid, 0);
      check("t6_level", fifo_level, 0);
      rst = 1'b1;
      m_tready = 1'b1;
      push(16'd9, rand_data());
      drain();

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         m_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            msg_valid = 1'b1;
            if ($urandom_range(0, 9) == 0)
               msg_length = $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(33, 300));
            else
               msg_length = 16'($urandom_range(1, MAXB));
            msg_data = rand_data();
         end else begin
            msg_valid = 1'b0;
         end
         tick(1);
      end
      drain();
`ifdef MSG_SERIALIZER_STATS_EN
      check("stat_in", stat_msgs_in, st_in);
      check("stat_out", stat_msgs_out, st_out);
      check("stat_drops", stat_drops, st_drop);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
